// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch-stage PC sequencer with RUN/HANDLER exception FSM, address checks and fetch counter
module if_fetch_ctrl #(
  parameter logic [31:0] PC_RESET   = 32'h00003000,
  parameter logic [31:0] HANDLER_PC = 32'h00004180,
  parameter logic [31:0] IM_BASE    = 32'h00003000,
  parameter int          IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [11:0] im_addr,
  output logic        if_flush,
  output logic        if_exc,
  output logic [4:0]  if_exccode,
  output logic        in_handler,
  output logic [31:0] fetch_cnt
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] HANDLER = 1'b1;
  localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;
  logic [0:0] state;
  logic take_exc, take_eret, advance;
  logic [31:0] pc_next;
  // exc_req/eret only count in their own state and beat stall
  always_comb begin
    take_exc = exc_req && state == RUN;
    take_eret = eret && state == HANDLER;
    advance = take_exc || take_eret || !stall;
    pc_next = take_exc ? HANDLER_PC : take_eret ? epc : stall ? pc : npc_sel ? npc_target : pc + 32'd4;
  end
  assign im_addr = 12'((pc - IM_BASE) >> 2);
  assign if_flush = reset && (take_exc || take_eret);
  assign if_exc = pc[1:0] != 2'b00 || pc < IM_BASE || pc > IM_LAST;
  assign if_exccode = if_exc ? 5'd4 : 5'd0;
  assign in_handler = state == HANDLER;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= PC_RESET;
      state <= RUN;
      fetch_cnt <= 32'd0;
    end else begin
      pc <= pc_next;
      state <= take_exc ? HANDLER : take_eret ? RUN : state;
      if (advance) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed vector table plus reset-in-handler sequence for if_fetch_ctrl
module tb_if_fetch_ctrl;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, npc_sel = 1'b0, exc_req = 1'b0, eret = 1'b0;
  logic [31:0] npc_target = 32'd0, epc = 32'd0;
  logic [31:0] pc, fetch_cnt;
  logic [11:0] im_addr;
  logic if_flush, if_exc, in_handler;
  logic [4:0] if_exccode;
  int total = 0, bad = 0;

  typedef struct {
    logic stall, npc_sel, exc_req, eret;
    logic [31:0] tgt, epc;
    logic flush;
    logic [31:0] pc;
    logic [11:0] im;
    logic hand;
    logic [31:0] cnt;
    logic exc;
  } vec_t;
  vec_t vq[$];

  if_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .npc_target(npc_target),
    .exc_req(exc_req), .eret(eret), .epc(epc), .pc(pc), .im_addr(im_addr), .if_flush(if_flush),
    .if_exc(if_exc), .if_exccode(if_exccode), .in_handler(in_handler), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic n, input logic [31:0] t, input logic x, input logic e,
                     input logic [31:0] ep, input logic fl, input logic [31:0] p, input logic [11:0] im,
                     input logic h, input logic [31:0] c, input logic ex);
    vec_t v;
    v.stall = s; v.npc_sel = n; v.tgt = t; v.exc_req = x; v.eret = e; v.epc = ep;
    v.flush = fl; v.pc = p; v.im = im; v.hand = h; v.cnt = c; v.exc = ex;
    vq.push_back(v);
  endtask

  task automatic post(input string tag, input logic [31:0] p, input logic [11:0] im, input logic h,
                      input logic [31:0] c, input logic ex);
    chk({tag, " pc"}, pc, p);
    chk({tag, " im_addr"}, 32'(im_addr), 32'(im));
    chk({tag, " in_handler"}, 32'(in_handler), 32'(h));
    chk({tag, " fetch_cnt"}, fetch_cnt, c);
    chk({tag, " if_exc"}, 32'(if_exc), 32'(ex));
    chk({tag, " if_exccode"}, 32'(if_exccode), ex ? 32'd4 : 32'd0);
  endtask

  initial begin
    //   stall npc tgt         exc eret epc         flush pc          im     hand cnt ex
    add(0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h3004, 12'd1,    0, 1,  0);
    add(0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h3008, 12'd2,    0, 2,  0);
    add(1, 0, 32'h0,       0, 0, 32'h0,       0, 32'h3008, 12'd2,    0, 2,  0);
    add(1, 0, 32'h0,       0, 0, 32'h0,       0, 32'h3008, 12'd2,    0, 2,  0);
    add(0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h300C, 12'd3,    0, 3,  0);
    add(0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h3010, 12'd4,    0, 4,  0);
    add(1, 0, 32'h0,       1, 0, 32'h0,       1, 32'h4180, 12'd1120, 1, 5,  0);
    add(0, 0, 32'h0,       1, 0, 32'h0,       0, 32'h4184, 12'd1121, 1, 6,  0);
    add(0, 0, 32'h0,       1, 1, 32'h3010,    1, 32'h3010, 12'd4,    0, 7,  0);
    add(0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h3014, 12'd5,    0, 8,  0);
    add(0, 0, 32'h0,       0, 1, 32'h5000,    0, 32'h3018, 12'd6,    0, 9,  0);
    add(0, 1, 32'h3002,    0, 0, 32'h0,       0, 32'h3002, 12'd0,    0, 10, 1);
    add(0, 1, 32'h7000,    0, 0, 32'h0,       0, 32'h7000, 12'd0,    0, 11, 1);
    add(0, 1, 32'h6FFC,    0, 0, 32'h0,       0, 32'h6FFC, 12'd4095, 0, 12, 0);
    add(0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h7000, 12'd0,    0, 13, 1);
    add(0, 1, 32'h2FFC,    0, 0, 32'h0,       0, 32'h2FFC, 12'd4095, 0, 14, 1);
    add(1, 1, 32'h3000,    0, 0, 32'h0,       0, 32'h2FFC, 12'd4095, 0, 14, 1);
    add(0, 1, 32'h3000,    0, 0, 32'h0,       0, 32'h3000, 12'd0,    0, 15, 0);
    add(1, 0, 32'h0,       0, 1, 32'h4444,    0, 32'h3000, 12'd0,    0, 15, 0);

    // reset must override a pending exception and suppress if_flush
    reset = 1'b0; exc_req = 1'b1;
    @(posedge clk); #1;
    chk("rst if_flush", 32'(if_flush), 32'd0);
    post("rst", 32'h3000, 12'd0, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    exc_req = 1'b0; reset = 1'b1;

    foreach (vq[i]) begin
      stall = vq[i].stall; npc_sel = vq[i].npc_sel; npc_target = vq[i].tgt;
      exc_req = vq[i].exc_req; eret = vq[i].eret; epc = vq[i].epc;
      #1;
      chk($sformatf("v%0d if_flush", i), 32'(if_flush), 32'(vq[i].flush));
      @(posedge clk); #1;
      post($sformatf("v%0d", i), vq[i].pc, vq[i].im, vq[i].hand, vq[i].cnt, vq[i].exc);
    end

    // enter handler, walk to 0x4190, then reset with eret pending
    stall = 1'b0; npc_sel = 1'b0; eret = 1'b0; exc_req = 1'b1;
    @(posedge clk); #1;
    exc_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    post("hnd", 32'h4190, 12'd1124, 1'b1, 32'd20, 1'b0);
    reset = 1'b0; eret = 1'b1; epc = 32'h3100;
    #1;
    chk("hrst if_flush", 32'(if_flush), 32'd0);
    @(posedge clk); #1;
    post("hrst", 32'h3000, 12'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("hrel if_flush", 32'(if_flush), 32'd0);
    @(posedge clk); #1;
    post("hrel", 32'h3004, 12'd1, 1'b0, 32'd1, 1'b0);
    eret = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL provide parameter PC_RESET, default 32'h00003000, first fetch address after reset.
REQ-002 SHALL provide parameter HANDLER_PC, default 32'h00004180, exception handler entry address.
REQ-003 SHALL provide parameter IM_BASE, default 32'h00003000, byte address of instruction memory word 0.
REQ-004 SHALL provide parameter IM_WORDS, default 4096, instruction memory depth in words.
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, all state updates on its rising edge
- reset  in  1  synchronous, active-low reset
- stall  in  1  hazard-unit freeze of the fetch stage
- npc_sel  in  1  branch/jump taken, redirect from decode
- npc_target  in  32  branch/jump target
- exc_req  in  1  exception/interrupt accepted by coprocessor 0
- eret  in  1  return from handler
- epc  in  32  return address for eret
- pc  out  32  current fetch address
- im_addr  out  12  word index to instruction memory
- if_flush  out  1  clear IF/ID register this cycle
- if_exc  out  1  fetch address error
- if_exccode  out  5  exception code for if_exc
- in_handler  out  1  1 while in state HANDLER
- fetch_cnt  out  32  count of fetch advances

Function
REQ-006 SHALL hold pc in a 32-bit register; all other outputs derive combinationally from registered state and current inputs, except fetch_cnt, which is registered.
REQ-007 SHALL drive im_addr = (pc - IM_BASE)[13:2].
REQ-008 SHALL implement a two-state FSM: RUN and HANDLER.
REQ-009 SHALL select next pc in priority order:
- reset
- exc_req in RUN -> HANDLER_PC
- eret in HANDLER -> epc
- stall -> hold pc
- npc_sel -> npc_target
- otherwise pc + 4, modulo 2^32
REQ-010 SHALL transition RUN->HANDLER on exc_req in RUN, and HANDLER->RUN on eret in HANDLER; no other transitions except reset.
REQ-011 SHALL ignore exc_req in HANDLER and ignore eret in RUN; the cycle then behaves per remaining priorities.
REQ-012 SHALL let exc_req and eret override stall in their respective states; the redirect takes effect on the same edge.
REQ-013 SHALL assert if_flush combinationally in exactly the cycle a redirect in REQ-010 is accepted; if_flush SHALL be 0 otherwise, including for npc_sel.
REQ-014 SHALL assert if_exc when pc[1:0] != 0, pc < IM_BASE, or pc > IM_BASE + 4*IM_WORDS - 4; if_exccode SHALL be 5'd4 (AdEL) when if_exc=1, else 5'd0.
REQ-015 SHALL not alter pc sequencing because of if_exc; reporting to coprocessor 0 is downstream.
REQ-016 SHALL increment fetch_cnt by 1 on every edge where pc changes value or is reloaded via a non-stall path, wrapping from 32'hFFFFFFFF to 0; fetch_cnt SHALL not increment on stalled holds.
REQ-017 SHALL drive in_handler = 1 iff the state is HANDLER.

Reset
REQ-018 SHALL, on a rising clk edge with reset=0, set pc=PC_RESET, state=RUN, and fetch_cnt=0, overriding all other inputs.
REQ-019 SHALL, while reset=0 after that edge, output im_addr=0, if_flush=0, if_exc=0, if_exccode=0, and in_handler=0.
REQ-020 SHALL make a reset asserted mid-handler return the FSM to RUN, with no pending eret remembered.

Verification
REQ-021 Release reset, run 3 idle cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; im_addr 0, 1, 2, 3; fetch_cnt=3.
REQ-022 stall=1 for 2 cycles at pc=0x3008 -> pc holds at 0x3008 and fetch_cnt holds; on release, pc=0x300C.
REQ-023 exc_req=1 with stall=1 at pc=0x3010 -> if_flush=1 that cycle; next pc=0x4180, im_addr=1120, in_handler=1; a second exc_req in HANDLER leaves pc=0x4184.
REQ-024 In HANDLER, eret=1 with epc=0x3010 and simultaneous exc_req=1 -> pc=0x3010, state RUN, if_flush=1 for one cycle only.
REQ-025 npc_sel=1 with npc_target=0x3002 -> pc=0x3002, if_exc=1, if_exccode=4, if_flush=0; same test with target 0x7000 -> if_exc=1.
REQ-026 Reset driven low while in HANDLER at pc=0x4190 -> next pc=0x3000, in_handler=0, fetch_cnt=0.
